// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: command codes,
// default sizes and the command priority encoder.
package pc_seq_pkg;

    localparam int PC_ADDR_W_DEF      = 8;
    localparam int PC_STACK_DEPTH_DEF = 4;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_NONE = 3'd0;
    localparam cmd_t CMD_INC  = 3'd1;
    localparam cmd_t CMD_BREL = 3'd2;
    localparam cmd_t CMD_JMP  = 3'd3;
    localparam cmd_t CMD_CALL = 3'd4;
    localparam cmd_t CMD_RET  = 3'd5;

    // Only the highest-priority strobe survives: ret > call > jmp > brel > inc.
    function automatic cmd_t pc_cmd_enc(input logic ena, input logic ret,
                                        input logic call, input logic jmp,
                                        input logic brel);
        if (!ena)      return CMD_NONE;
        else if (ret)  return CMD_RET;
        else if (call) return CMD_CALL;
        else if (jmp)  return CMD_JMP;
        else if (brel) return CMD_BREL;
        else           return CMD_INC;
    endfunction

endpackage

// File: rtl/pc_seq_stack.sv
// Return-address LIFO with depth/full/empty; PC_SEQ_CIRC_STACK_EN makes a push
// when full overwrite the oldest entry instead of being refused.
module pc_seq_stack
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = PC_ADDR_W_DEF,
    parameter int STACK_DEPTH = PC_STACK_DEPTH_DEF,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_dat,
    output logic [ADDR_W-1:0] top_dat,
    output logic [DEPTH_W-1:0] depth,
    output logic              full,
    output logic              empty,
    output logic              can_push
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(STACK_DEPTH - 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  wr_inc;
    logic [PTR_W-1:0]  rd_ptr;

    // The pointer walks a ring so that circular mode simply keeps writing
    // past the oldest entry; in bounded mode the ring never wraps over data.
    assign wr_inc  = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr  = (wr_ptr == '0) ? PTR_LAST : wr_ptr - 1'b1;
    assign top_dat = mem[rd_ptr];
    assign full    = (depth == DEPTH_MAX);
    assign empty   = (depth == '0);

`ifdef PC_SEQ_CIRC_STACK_EN
    assign can_push = 1'b1;
`else
    assign can_push = !full;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            depth  <= '0;
        end else if (push && can_push) begin
            wr_ptr <= wr_inc;
            if (!full) depth <= depth + 1'b1;
        end else if (pop && !empty) begin
            wr_ptr <= rd_ptr;
            depth  <= depth - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push && can_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/pc_seq.sv
// Program counter with relative branch, call/return stack and sticky stack error.
// Optional circular return stack via PC_SEQ_CIRC_STACK_EN.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W      = PC_ADDR_W_DEF,
    parameter int                STACK_DEPTH = PC_STACK_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ena,
    input  logic                             jmp,
    input  logic                             brel,
    input  logic                             call,
    input  logic                             ret,
    input  logic [ADDR_W-1:0]                jump_addr,
    input  logic [ADDR_W-1:0]                rel_off,
    output logic [ADDR_W-1:0]                imem_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             stack_err
);

    cmd_t              cmd;
    logic [ADDR_W-1:0] nxt;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] top_dat;
    logic              push;
    logic              pop;
    logic              err_set;
    logic              can_push;

    assign cmd = pc_cmd_enc(ena, ret, call, jmp, brel);
    assign nxt = imem_addr + 1'b1;

    pc_seq_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_dat (nxt),
        .top_dat  (top_dat),
        .depth    (depth),
        .full     (stack_full),
        .empty    (stack_empty),
        .can_push (can_push)
    );

    always_comb begin
        pc_d    = imem_addr;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        case (cmd)
            CMD_INC:  pc_d = nxt;
            CMD_BREL: pc_d = nxt + rel_off;
            CMD_JMP:  pc_d = jump_addr;
            CMD_CALL: begin
                // A refused call degrades to a plain increment.
                if (can_push) begin
                    push = 1'b1;
                    pc_d = jump_addr;
                end else begin
                    pc_d    = nxt;
                    err_set = 1'b1;
                end
            end
            CMD_RET: begin
                if (!stack_empty) begin
                    pop  = 1'b1;
                    pc_d = top_dat;
                end else begin
                    pc_d    = nxt;
                    err_set = 1'b1;
                end
            end
            default: pc_d = imem_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_addr <= RESET_ADDR;
            stack_err <= 1'b0;
        end else begin
            imem_addr <= pc_d;
            if (err_set) stack_err <= 1'b1;
        end
    end

endmodule
